// File: rtl/char_stream_framer_pkg.sv
// Shared definitions for the character stream framer: ASCII codes, output FSM
// encoding and the FIFO entry layout.
package char_stream_framer_pkg;

    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    localparam int unsigned LEN_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } out_state_e;

    // Marker entries carry the finished password's length and overflow flag.
    typedef struct packed {
        logic             eop;
        logic [7:0]       data;
        logic [LEN_W-1:0] len;
        logic             too_long;
    } fifo_entry_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI);
    endfunction

endpackage

// File: rtl/char_stream_framer_if.sv
// Upstream character handshake and downstream checker stream of the framer.
interface char_stream_framer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_hold;
    logic       out_en;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eop;

    modport master (
        output in_valid, in_data, out_hold,
        input  in_ready, out_en, out_data, out_sof, out_eop
    );

    modport slave (
        input  in_valid, in_data, out_hold,
        output in_ready, out_en, out_data, out_sof, out_eop
    );
endinterface

// File: rtl/char_stream_framer_sync_fifo_ptr.sv
// Synchronous FIFO with wrap-bit binary pointers; head is read combinationally.
module sync_fifo_ptr #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/char_stream_framer.sv
// Input stage of the password checker: filters keypad/UART characters, frames
// passwords on CR and replays them as a one-character-per-cycle enable stream.
module char_stream_framer
    import char_stream_framer_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    char_stream_framer_if.slave  bus,
    output logic [LEN_W-1:0]     pw_len,
    output logic                 pw_too_long,
    output logic [7:0]           drop_cnt
);
    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic             ready;
    logic             accept;
    logic             printable;
    logic             is_cr;
    logic             room;

    logic [LEN_W-1:0] word_cnt;
    logic             too_long;

    out_state_e       state_q, state_d;
    logic             out_en_q, out_en_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eop_q, out_eop_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [LEN_W-1:0] pw_len_d;
    logic             pw_too_long_d;

    // Ready is forced low while reset is asserted, otherwise it tracks !full.
    assign ready        = rst && !fifo_full;
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;
    assign printable    = is_printable(bus.in_data);
    assign is_cr        = (bus.in_data == ASCII_CR);
    assign room         = (word_cnt < LEN_W'(MAX_LEN));

    // Classification of the accepted character into a data entry or a marker.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            if (printable && room) begin
                push            = 1'b1;
                push_entry.data = bus.in_data;
            end else if (is_cr && (word_cnt != '0)) begin
                push                = 1'b1;
                push_entry.eop      = 1'b1;
                push_entry.len      = word_cnt;
                push_entry.too_long = too_long;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            too_long <= 1'b0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (printable) begin
                if (room) word_cnt <= word_cnt + LEN_W'(1);
                else      too_long <= 1'b1;
            end else if (is_cr) begin
                word_cnt <= '0;
                too_long <= 1'b0;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    sync_fifo_ptr #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Output FSM next-state and next-output logic; pop is the only combinational output.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        out_en_d      = 1'b0;
        out_sof_d     = 1'b0;
        out_eop_d     = 1'b0;
        out_data_d    = out_data_q;
        pw_len_d      = pw_len;
        pw_too_long_d = pw_too_long;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.out_hold) begin
                    pop = 1'b1;
                    if (!head.eop) begin
                        out_en_d   = 1'b1;
                        out_sof_d  = 1'b1;
                        out_data_d = head.data;
                        state_d    = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (!fifo_empty && !bus.out_hold) begin
                    pop = 1'b1;
                    if (head.eop) begin
                        out_eop_d     = 1'b1;
                        pw_len_d      = head.len;
                        pw_too_long_d = head.too_long;
                        state_d       = ST_GAP;
                    end else begin
                        out_en_d   = 1'b1;
                        out_data_d = head.data;
                    end
                end
            end
            ST_GAP: begin
                if (!bus.out_hold) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_en_q    <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            pw_len      <= '0;
            pw_too_long <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_en_q    <= out_en_d;
            out_sof_q   <= out_sof_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            pw_len      <= pw_len_d;
            pw_too_long <= pw_too_long_d;
        end
    end

    assign bus.out_en   = out_en_q;
    assign bus.out_sof  = out_sof_q;
    assign bus.out_eop  = out_eop_q;
    assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_char_stream_framer.sv
// Scoreboard bench for char_stream_framer: stimulus pushes expected stream
// events from a password-level model, a monitor pops and compares them.
module tb_char_stream_framer;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned MAX_LEN = 4;

    typedef struct {
        bit       is_eop;
        bit [7:0] data;
        bit       sof;
        int       len;
        bit       tl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] pw_len;
    logic       pw_too_long;
    logic [7:0] drop_cnt;

    char_stream_framer_if ifc ();

    char_stream_framer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .pw_len      (pw_len),
        .pw_too_long (pw_too_long),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   evt_cyc[$];
    int   cyc = 0;
    int   n_emit = 0;
    bit   gap_pend = 0;

    // Password-level reference state
    int m_wc = 0;
    bit m_tl = 0;
    int m_drops = 0;
    int m_len = 0;
    bit m_pwtl = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, req, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_wc = 0; m_tl = 0; m_drops = 0; m_len = 0; m_pwtl = 0;
    endfunction

    function automatic void model_accept(input bit [7:0] c);
        exp_t e;
        e = '{is_eop: 0, data: c, sof: 0, len: 0, tl: 0};
        if (c >= 8'h20 && c <= 8'h7E) begin
            if (m_wc < MAX_LEN) begin
                e.sof = (m_wc == 0);
                exp_q.push_back(e);
                m_wc++;
            end else begin
                m_tl = 1;
            end
        end else if (c == 8'h0D) begin
            if (m_wc > 0) begin
                e.is_eop = 1; e.data = 0; e.len = m_wc; e.tl = m_tl;
                exp_q.push_back(e);
            end
            m_wc = 0; m_tl = 0;
        end else begin
            if (m_drops < 255) m_drops++;
        end
    endfunction

    // Monitor: compares every emitted event against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            gap_pend = 0;
        end else if (gap_pend) begin
            chk("gap_strobes", {29'd0, ifc.out_en, ifc.out_sof, ifc.out_eop}, 0);
            gap_pend = 0;
        end else begin
            if (ifc.out_en) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_char", int'(ifc.out_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("char_kind", 0, int'(e.is_eop));
                    chk("char_data", int'(ifc.out_data), int'(e.data));
                    chk("char_sof", int'(ifc.out_sof), int'(e.sof));
                end
                n_emit++;
                evt_cyc.push_back(cyc);
            end else begin
                chk("sof_without_en", int'(ifc.out_sof), 0);
            end
            if (ifc.out_eop) begin
                chk("eop_with_en", int'(ifc.out_en), 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_eop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("eop_kind", 1, int'(e.is_eop));
                    chk("pw_len", int'(pw_len), e.len);
                    chk("pw_too_long", int'(pw_too_long), int'(e.tl));
                    m_len = e.len;
                    m_pwtl = e.tl;
                end
                gap_pend = 1;
                evt_cyc.push_back(cyc);
            end else begin
                chk("pw_len_hold", int'(pw_len), m_len);
                chk("pw_too_long_hold", int'(pw_too_long), int'(m_pwtl));
            end
        end
    end

    task automatic send(input bit [7:0] c, input bit rh);
        int  t;
        bit  done;
        t = 0;
        done = 0;
        if (rh && ($urandom % 3 == 0)) begin
            ifc.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = c;
        while (!done) begin
            if (rh) ifc.out_hold = ($urandom % 5 == 0);
            @(negedge clk);
            if (ifc.in_ready) begin
                model_accept(c);
                done = 1;
            end else if (++t > 200) begin
                chk("send_timeout", 1, 0);
                done = 1;
            end
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        ifc.out_hold = 1'b0;
        while ((exp_q.size() != 0 || gap_pend) && t < 300) begin
            @(posedge clk); #2;
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    bit [7:0] c;
    int       base;

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        ifc.out_hold = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(ifc.in_ready), 0);
        chk("rst_out_en", int'(ifc.out_en), 0);
        chk("rst_out_eop", int'(ifc.out_eop), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(ifc.in_ready), 1);
        @(posedge clk); #1;

        // Basic password with back-to-back characters
        evt_cyc.delete();
        send_str("ab1\r");
        drain();
        chk("t1_events", evt_cyc.size(), 4);
        if (evt_cyc.size() == 4)
            for (int i = 0; i < 3; i++) chk("t1_consecutive", evt_cyc[i+1] - evt_cyc[i], 1);
        chk("t1_pw_len", int'(pw_len), 3);

        // Non-printables dropped
        send(8'h07, 1'b0); send(8'h0A, 1'b0); send_str("x\r");
        drain();
        chk("t2_drop_cnt", int'(drop_cnt), m_drops);
        chk("t2_drop_cnt_abs", int'(drop_cnt), 2);
        chk("t2_pw_len", int'(pw_len), 1);

        // Truncation past MAX_LEN
        send_str("abcdefg\r");
        drain();
        chk("t3_pw_len", int'(pw_len), 4);
        chk("t3_too_long", int'(pw_too_long), 1);

        // Backpressure: fill the FIFO while held
        ifc.out_hold = 1'b1;
        send_str("abc\rdef\r");
        @(negedge clk);
        chk("t4_full_ready", int'(ifc.in_ready), 0);
        @(posedge clk); #1;
        ifc.out_hold = 1'b0;
        @(negedge clk);
        chk("t4_ready_before_pop", int'(ifc.in_ready), 0);
        @(negedge clk);
        chk("t4_ready_after_pop", int'(ifc.in_ready), 1);
        @(posedge clk); #1;
        send_str("gh\r");
        drain();

        // Two passwords back-to-back
        send_str("ab\rcd\r");
        drain();
        chk("t5_pw_len", int'(pw_len), 2);

        // Randomised traffic with random hold and valid gaps
        for (int n = 0; n < 400; n++) begin
            case ($urandom % 10)
                0, 1, 2, 3, 4, 5: c = 8'($urandom_range(32, 126));
                6, 7:             c = 8'h0D;
                8:  begin c = 8'($urandom_range(0, 31)); if (c == 8'h0D) c = 8'h1B; end
                default:          c = 8'($urandom_range(127, 255));
            endcase
            send(c, 1'b1);
        end
        send(8'h0D, 1'b1);
        drain();
        chk("rand_drop_cnt", int'(drop_cnt), m_drops);

        // drop_cnt saturation
        for (int n = 0; n < 260; n++) send(8'h01, 1'b0);
        drain();
        chk("sat_drop_cnt", int'(drop_cnt), 255);

        // Asynchronous reset in the middle of a password
        base = n_emit;
        ifc.out_hold = 1'b1;
        send_str("vwxyz");
        ifc.out_hold = 1'b0;
        for (int t = 0; t < 50 && n_emit < base + 2; t++) begin
            @(posedge clk); #2;
        end
        chk("mid_emitted", (n_emit >= base + 2) ? 1 : 0, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_en", int'(ifc.out_en), 0);
        chk("mid_rst_out_sof", int'(ifc.out_sof), 0);
        chk("mid_rst_out_eop", int'(ifc.out_eop), 0);
        chk("mid_rst_out_data", int'(ifc.out_data), 0);
        chk("mid_rst_pw_len", int'(pw_len), 0);
        chk("mid_rst_drop_cnt", int'(drop_cnt), 0);
        chk("mid_rst_in_ready", int'(ifc.in_ready), 0);
        exp_q.delete();
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_mid_in_ready", int'(ifc.in_ready), 1);
        @(posedge clk); #1;
        send_str("ok\r");
        drain();
        chk("post_mid_pw_len", int'(pw_len), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
